// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin I/D-cache arbiter onto one fixed-latency memory port.
// Define MEM_ARB_DCACHE_PRIO_EN to give the D-cache fixed priority on ties.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [DATA_W-1:0] ic_data_in,
    input  logic              ic_rd,
    input  logic              ic_wr,
    output logic [DATA_W-1:0] ic_data_out,
    output logic              ic_done,
    output logic              ic_stall,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_data_in,
    input  logic              dc_rd,
    input  logic              dc_wr,
    output logic [DATA_W-1:0] dc_data_out,
    output logic              dc_done,
    output logic              dc_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_stall,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              req_err
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic owner, wr_l, last_grant;
    logic ic_req, dc_req, pick_dc, win_rd, win_wr;
    assign ic_req = ic_rd | ic_wr;
    assign dc_req = dc_rd | dc_wr;
`ifdef MEM_ARB_DCACHE_PRIO_EN
    assign pick_dc = dc_req;
`else
    // owner/last_grant encoding: 0 = I-cache, 1 = D-cache
    assign pick_dc = dc_req & (~ic_req | ~last_grant);
`endif
    assign win_rd = pick_dc ? dc_rd : ic_rd;
    assign win_wr = pick_dc ? dc_wr : ic_wr;
    assign busy = state != IDLE;
    assign req_err = (state == IDLE) & win_rd & win_wr;
    assign mem_rd = (state == ISSUE) & ~mem_stall & ~wr_l;
    assign mem_wr = (state == ISSUE) & ~mem_stall & wr_l;
    assign ic_done = (state == RESP) & ~owner;
    assign dc_done = (state == RESP) & owner;
    assign ic_stall = ic_req & ~ic_done;
    assign dc_stall = dc_req & ~dc_done;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            owner       <= 1'b0;
            wr_l        <= 1'b0;
            last_grant  <= 1'b1;
            mem_addr    <= '0;
            mem_data_in <= '0;
            ic_data_out <= '0;
            dc_data_out <= '0;
        end else begin
            case (state)
                IDLE: if (ic_req | dc_req) begin
                    owner       <= pick_dc;
                    wr_l        <= win_wr;
                    mem_addr    <= pick_dc ? dc_addr : ic_addr;
                    mem_data_in <= pick_dc ? dc_data_in : ic_data_in;
                    state       <= ISSUE;
                end
                ISSUE: if (!mem_stall) begin
                    cnt   <= CNT_W'(MEM_LAT - 1);
                    state <= WAIT;
                end
                WAIT: if (cnt == '0) begin
                    if (!wr_l && !owner) ic_data_out <= mem_data_out;
                    if (!wr_l && owner) dc_data_out <= mem_data_out;
                    state <= RESP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: begin
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-timing model.
module tb_mem_arbiter;
    localparam int MEM_LAT = 4;
`ifdef MEM_ARB_DCACHE_PRIO_EN
    localparam bit DPRIO = 1'b1;
`else
    localparam bit DPRIO = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0;
    logic [31:0] ic_addr = '0, ic_data_in = '0, dc_addr = '0, dc_data_in = '0, mem_data_out = '0;
    logic ic_rd = 1'b0, ic_wr = 1'b0, dc_rd = 1'b0, dc_wr = 1'b0, mem_stall = 1'b0;
    logic [31:0] ic_data_out, dc_data_out, mem_addr, mem_data_in;
    logic ic_done, ic_stall, dc_done, dc_stall, mem_rd, mem_wr, busy, req_err;
    int checks = 0, errors = 0, cyc = 0;
    bit m_ok, m_act, m_issued, m_own, m_wr, m_last, rand_mode;
    bit req_i, req_d, pd, k_done;
    bit e_done [2];
    int m_issue_t, k;
    logic [31:0] m_addr, m_din, mem_word = 32'hDEAD_BEEF;
    logic [31:0] m_q [2];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .ic_addr(ic_addr), .ic_data_in(ic_data_in), .ic_rd(ic_rd), .ic_wr(ic_wr),
        .ic_data_out(ic_data_out), .ic_done(ic_done), .ic_stall(ic_stall),
        .dc_addr(dc_addr), .dc_data_in(dc_data_in), .dc_rd(dc_rd), .dc_wr(dc_wr),
        .dc_data_out(dc_data_out), .dc_done(dc_done), .dc_stall(dc_stall),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_stall(mem_stall), .mem_data_out(mem_data_out), .busy(busy), .req_err(req_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Tie goes to the requester that was not served last (1 = D-cache), or always D with priority.
    function automatic bit pick_d(input bit i, input bit d, input bit last);
        if (DPRIO) return d;
        if (i && d) return !last;
        return d;
    endfunction

    function automatic logic [1:0] new_req;
        int sel;
        if ($urandom_range(0, 9) < 6) return 2'b00;
        sel = $urandom_range(0, 9);
        return sel == 0 ? 2'b11 : (sel < 5 ? 2'b01 : 2'b10);
    endfunction

    // Model: a grant starts a transaction; issue happens on the first unstalled cycle after it,
    // read data is valid MEM_LAT cycles after issue, done follows one cycle later.
    always @(negedge clk) begin
        req_i = ic_rd | ic_wr;
        req_d = dc_rd | dc_wr;
        pd = pick_d(req_i, req_d, m_last);
        k = cyc - m_issue_t;
        k_done = m_act && m_issued && k == MEM_LAT + 1;
        e_done[0] = k_done && !m_own;
        e_done[1] = k_done && m_own;
        if (m_ok) begin
            chk("busy", busy, m_act);
            chk("mem_rd", mem_rd, m_act && !m_issued && !mem_stall && !m_wr);
            chk("mem_wr", mem_wr, m_act && !m_issued && !mem_stall && m_wr);
            chk("req_err", req_err, !m_act && (pd ? dc_rd && dc_wr : ic_rd && ic_wr));
            chk("ic_done", ic_done, e_done[0]);
            chk("dc_done", dc_done, e_done[1]);
            chk("ic_stall", ic_stall, req_i && !e_done[0]);
            chk("dc_stall", dc_stall, req_d && !e_done[1]);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_data_in", mem_data_in, m_din);
            chk("ic_data_out", ic_data_out, m_q[0]);
            chk("dc_data_out", dc_data_out, m_q[1]);
        end
        if (!rst) begin
            m_ok = 1'b1; m_act = 1'b0; m_issued = 1'b0; m_last = 1'b1;
            m_addr = '0; m_din = '0; m_q[0] = '0; m_q[1] = '0;
        end else if (!m_act) begin
            if (req_i || req_d) begin
                m_act = 1'b1; m_issued = 1'b0; m_own = pd;
                m_wr = pd ? dc_wr : ic_wr;
                m_addr = pd ? dc_addr : ic_addr;
                m_din = pd ? dc_data_in : ic_data_in;
            end
        end else if (!m_issued) begin
            if (!mem_stall) begin
                m_issued = 1'b1;
                m_issue_t = cyc;
            end
        end else begin
            if (k == MEM_LAT && !m_wr) m_q[m_own] = mem_data_out;
            if (k_done) begin
                m_act = 1'b0;
                m_last = m_own;
            end
        end
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        mem_data_out = (m_act && m_issued && cyc - m_issue_t == MEM_LAT && !rand_mode) ? mem_word : $urandom;
    end

    task automatic do_reset(input logic [31:0] w);
        rst = 1'b0;
        {ic_rd, ic_wr, dc_rd, dc_wr, mem_stall} = '0;
        tick;
        tick;
        rst = 1'b1;
        @(negedge clk);
        mem_word = w;
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data_in", mem_data_in, 0);
        chk("rst_ic_data_out", ic_data_out, 0);
        chk("rst_dc_data_out", dc_data_out, 0);
        chk("rst_strobes", {ic_done, dc_done, mem_rd, mem_wr, req_err}, 0);
        tick;
    endtask

    initial begin
        int n;
        logic [3:0] order, exp_order;
        logic [1:0] r;
        exp_order = DPRIO ? 4'b1111 : 4'b1010;
        order = '0;
        do_reset(32'hDEAD_BEEF);
        // single I-cache read
        ic_rd = 1'b1; ic_addr = 32'h100;
        for (int c = 0; c <= 7; c++) begin
            if (c == 7) ic_rd = 1'b0;
            @(negedge clk);
            if (c == 1) chk("s1_mem_addr", mem_addr, 32'h100);
            chk("s1_mem_rd", mem_rd, c == 1);
            if (c == 6) chk("s1_ic_done", ic_done, 1);
            if (c == 7) chk("s1_ic_data_out", ic_data_out, 32'hDEAD_BEEF);
            chk("s1_dc_done", dc_done, 0);
            tick;
        end
        do_reset(32'hCAFE_0002);
        // simultaneous reads right after reset
        ic_rd = 1'b1; dc_rd = 1'b1; ic_addr = 32'h10; dc_addr = 32'h20;
        for (int c = 0; c <= 14; c++) begin
            if (c == 7) begin
                if (DPRIO) dc_rd = 1'b0;
                else ic_rd = 1'b0;
            end
            if (c == 14) {ic_rd, dc_rd} = 2'b00;
            @(negedge clk);
            if (c == 6) chk("s2_first_done", DPRIO ? dc_done : ic_done, 1);
            if (c == 13) chk("s2_second_done", DPRIO ? ic_done : dc_done, 1);
            if (c <= 12) chk("s2_second_stall", DPRIO ? ic_stall : dc_stall, 1);
            if (c == 8) chk("s2_second_issue", mem_rd, 1);
            tick;
        end
        // continuous re-requests from both sides
        ic_rd = 1'b1; dc_rd = 1'b1; n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (ic_done || dc_done) begin
                order[n] = dc_done;
                n++;
            end
            tick;
        end
        {ic_rd, dc_rd} = 2'b00;
        chk("s3_grants", n, 4);
        for (int j = 0; j < 4; j++) chk("s3_order", order[j], exp_order[j]);
        // D-cache write with stalled issue
        dc_wr = 1'b1; dc_addr = 32'h40; dc_data_in = 32'h1234_5678;
        for (int c = 0; c <= 10; c++) begin
            mem_stall = c >= 1 && c <= 3;
            if (c == 10) dc_wr = 1'b0;
            @(negedge clk);
            if (c >= 1 && c <= 4) chk("s4_mem_wr", mem_wr, c == 4);
            if (c == 4) chk("s4_mem_data_in", mem_data_in, 32'h1234_5678);
            if (c == 4) chk("s4_mem_addr", mem_addr, 32'h40);
            if (c == 8 || c == 9) chk("s4_dc_done", dc_done, c == 9);
            if (c == 10) chk("s4_dc_data_out", dc_data_out, 32'hCAFE_0002);
            tick;
        end
        // reset during WAIT
        ic_rd = 1'b1; ic_addr = 32'h200;
        for (int c = 0; c <= 3; c++) begin
            if (c == 3) rst = 1'b0;
            @(negedge clk);
            if (c >= 2) chk("s5_busy", busy, 1);
            tick;
        end
        rst = 1'b1; ic_rd = 1'b0;
        @(negedge clk);
        chk("s5_outputs", {busy, mem_rd, mem_wr, ic_done, dc_done, req_err}, 0);
        chk("s5_mem_addr", mem_addr, 0);
        chk("s5_ic_data_out", ic_data_out, 0);
        chk("s5_dc_data_out", dc_data_out, 0);
        tick;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("s5_no_done", ic_done, 0);
            tick;
        end
        dc_rd = 1'b1; dc_addr = 32'h300;
        for (int c = 0; c <= 7; c++) begin
            if (c == 7) dc_rd = 1'b0;
            @(negedge clk);
            if (c == 6) chk("s5_later_done", dc_done, 1);
            if (c == 7) chk("s5_later_data", dc_data_out, 32'hCAFE_0002);
            tick;
        end
        // rd and wr together
        dc_rd = 1'b1; dc_wr = 1'b1; dc_addr = 32'h80; dc_data_in = 32'h55AA_55AA;
        for (int c = 0; c <= 7; c++) begin
            if (c == 7) {dc_rd, dc_wr} = 2'b00;
            @(negedge clk);
            if (c <= 1) chk("s6_req_err", req_err, c == 0);
            if (c == 1) chk("s6_mem_wr", mem_wr, 1);
            if (c == 1) chk("s6_mem_rd", mem_rd, 0);
            if (c == 6) chk("s6_dc_done", dc_done, 1);
            if (c == 7) chk("s6_dc_data_out", dc_data_out, 32'hCAFE_0002);
            tick;
        end
        @(negedge clk);
        rand_mode = 1'b1;
        tick;
        for (int c = 0; c < 3000; c++) begin
            rst = $urandom_range(0, 599) != 0;
            if (!rst) begin
                {ic_rd, ic_wr, dc_rd, dc_wr} = '0;
            end else begin
                if (!(ic_rd | ic_wr) || e_done[0]) begin
                    r = new_req();
                    {ic_rd, ic_wr} = r;
                    ic_addr = $urandom;
                    ic_data_in = $urandom;
                end
                if (!(dc_rd | dc_wr) || e_done[1]) begin
                    r = new_req();
                    {dc_rd, dc_wr} = r;
                    dc_addr = $urandom;
                    dc_data_in = $urandom;
                end
            end
            mem_stall = $urandom_range(0, 3) == 0;
            tick;
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
